dm_abstract_reg_access: RTL and testbench



---
 rtl/dm_abstract_reg_access.sv | 179 +++++++++++++++++
 tb/tb_dm_abstract_reg_access.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_abstract_reg_access.sv
// dm_abstract_reg_access
//   Debug Module initiator for the GPR debug access bus. Accepts RISC-V
//   Access Register abstract commands (cmdtype 0), validates them, and runs
//   one bus transaction per accepted transfer. Read data is captured into
//   data0, and data0 is driven onto the bus for writes. The block also
//   maintains busy, the sticky cmderr and the regno postincrement.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cmd_valid_i, cmd_i       DMI write to the command register
//   data0_wr_en_i, data0_i   DMI write to data0
//   cmderr_clr_i             write-1-to-clear pulse for cmderr
//   halted_i                 hart halted
//   data0_o                  data0 register
//   busy_o, cmderr_o         abstractcs.busy / abstractcs.cmderr
//   cmd_regno_o              current regno (postincremented)
//   dm_reg_rd_wr_en_o        bus request
//   dm_reg_rd_wr_o           1 = write, 0 = read
//   dm_reg_rd_wr_address_o   GPR address {8'h10, 3'b000, index}
//   dm_reg_rd_wr_data_io     bidirectional data bus (driven only on writes)
//   DSP_reg_access_o         qualifies the GPR read driver
module dm_abstract_reg_access #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter logic [15:0] GPR_BASE      = 16'h1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic        data0_wr_en_i,
  input  logic [31:0] data0_i,
  input  logic        cmderr_clr_i,
  input  logic        halted_i,
  output logic [31:0] data0_o,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  output logic [15:0] cmd_regno_o,
  output logic        dm_reg_rd_wr_en_o,
  output logic        dm_reg_rd_wr_o,
  output logic [15:0] dm_reg_rd_wr_address_o,
  inout  logic [31:0] dm_reg_rd_wr_data_io,
  output logic        DSP_reg_access_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [2:0] ERR_BUSY      = 3'd1;
  localparam logic [2:0] ERR_NOT_SUPP  = 3'd2;
  localparam logic [2:0] ERR_EXCEPTION = 3'd3;
  localparam logic [2:0] ERR_HALT      = 3'd4;
  localparam logic [3:0] LAST_CNT      = 4'(ACCESS_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] data0_q;
  logic        busy_q;
  logic [2:0]  cmderr_q;
  logic [15:0] regno_q;
  logic        postinc_q;
  logic        en_q;
  logic        rd_wr_q;
  logic [15:0] addr_q;

  // Command field decode
  logic [7:0]  cmd_type;
  logic [2:0]  cmd_aarsize;
  logic        cmd_postinc;
  logic        cmd_postexec;
  logic        cmd_transfer;
  logic        cmd_write;
  logic [15:0] cmd_regno;
  logic [15:0] regno_off;
  logic        regno_in_range;
  logic [2:0]  chk_err;
  logic        unused_cmd_bit;

  assign cmd_type       = cmd_i[31:24];
  assign cmd_aarsize    = cmd_i[22:20];
  assign cmd_postinc    = cmd_i[19];
  assign cmd_postexec   = cmd_i[18];
  assign cmd_transfer   = cmd_i[17];
  assign cmd_write      = cmd_i[16];
  assign cmd_regno      = cmd_i[15:0];
  assign unused_cmd_bit = cmd_i[23];

  assign regno_off      = cmd_regno - GPR_BASE;
  assign regno_in_range = (cmd_regno >= GPR_BASE) && (regno_off < 16'd32);

  // Command checks in priority order; first failure wins
  always_comb begin
    chk_err = '0;
    if (cmd_type != 8'd0)                        chk_err = ERR_NOT_SUPP;
    else if (cmd_aarsize != 3'd2)                chk_err = ERR_NOT_SUPP;
    else if (cmd_postexec)                       chk_err = ERR_NOT_SUPP;
    else if (!halted_i)                          chk_err = ERR_HALT;
    else if (cmd_transfer && !regno_in_range)    chk_err = ERR_EXCEPTION;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data0_q   <= '0;
      busy_q    <= 1'b0;
      cmderr_q  <= '0;
      regno_q   <= '0;
      postinc_q <= 1'b0;
      en_q      <= 1'b0;
      rd_wr_q   <= 1'b0;
      addr_q    <= '0;
    end else begin
      // Error setting takes precedence over the write-1-to-clear
      if (busy_q && (cmd_valid_i || data0_wr_en_i) && (cmderr_q == 3'd0)) begin
        cmderr_q <= ERR_BUSY;
      end else if (!busy_q && cmd_valid_i && (cmderr_q == 3'd0) && (chk_err != 3'd0)) begin
        cmderr_q <= chk_err;
      end else if (cmderr_clr_i) begin
        cmderr_q <= '0;
      end

      if (!busy_q && data0_wr_en_i) begin
        data0_q <= data0_i;
      end

      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i && (cmderr_q == 3'd0) && (chk_err == 3'd0)) begin
            regno_q   <= cmd_regno;
            postinc_q <= cmd_postinc;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            if (cmd_transfer) begin
              state_q <= ACCESS;
              en_q    <= 1'b1;
              rd_wr_q <= cmd_write;
              addr_q  <= {8'h10, 3'b000, regno_off[4:0]};
            end else begin
              state_q <= DONE;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            if (!rd_wr_q) begin
              data0_q <= dm_reg_rd_wr_data_io;
            end
            en_q    <= 1'b0;
            rd_wr_q <= 1'b0;
            addr_q  <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (postinc_q) begin
            regno_q <= regno_q + 16'd1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus is driven only during a write access; reads leave it to the GPR
  assign dm_reg_rd_wr_data_io   = (en_q && rd_wr_q) ? data0_q : 'z;

  assign data0_o                = data0_q;
  assign busy_o                 = busy_q;
  assign cmderr_o               = cmderr_q;
  assign cmd_regno_o            = regno_q;
  assign dm_reg_rd_wr_en_o      = en_q;
  assign dm_reg_rd_wr_o         = rd_wr_q;
  assign dm_reg_rd_wr_address_o = addr_q;
  assign DSP_reg_access_o       = en_q;

endmodule

// File: tb/tb_dm_abstract_reg_access.sv
// Bench for dm_abstract_reg_access: two instances (ACCESS_CYCLES 1 and 3)
// share stimulus; each has a transaction-level model and a per-cycle compare.
// The bench acts as the GPR: it drives read data during reads and a fixed
// idle pattern whenever the DM is not supposed to be driving the bus.
module tb_dm_abstract_reg_access;
  localparam logic [15:0] GPR_BASE = 16'h1000;
  localparam logic [31:0] IDLE_PAT = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd = '0;
  logic        d0_we = 1'b0;
  logic [31:0] d0_in = '0;
  logic        clr = 1'b0;
  logic        halted = 1'b1;
  logic [31:0] gpr [32];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  // Abstract command acceptance rules
  function automatic logic [2:0] spec_err(input logic [31:0] c, input logic h);
    if (c[31:24] != 8'd0) return 3'd2;
    if (c[22:20] != 3'd2) return 3'd2;
    if (c[18]) return 3'd2;
    if (!h) return 3'd4;
    if (c[17] && ((c[15:0] < GPR_BASE) || (c[15:0] > GPR_BASE + 16'd31))) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [4:0] gpr_idx(input logic [15:0] r);
    logic [15:0] t;
    t = r - GPR_BASE;
    return t[4:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned AC = (g == 0) ? 1 : 3;
    logic [31:0] data0;
    logic        busy;
    logic [2:0]  cmderr;
    logic [15:0] regno;
    logic        en, rdwr, dsp;
    logic [15:0] addr;
    wire  [31:0] bus;

    assign bus = (en && rdwr) ? 32'bz : (en ? gpr[addr[4:0]] : IDLE_PAT);

    dm_abstract_reg_access #(.ACCESS_CYCLES(AC), .GPR_BASE(GPR_BASE)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_i(cmd),
      .data0_wr_en_i(d0_we), .data0_i(d0_in),
      .cmderr_clr_i(clr), .halted_i(halted),
      .data0_o(data0), .busy_o(busy), .cmderr_o(cmderr), .cmd_regno_o(regno),
      .dm_reg_rd_wr_en_o(en), .dm_reg_rd_wr_o(rdwr),
      .dm_reg_rd_wr_address_o(addr), .dm_reg_rd_wr_data_io(bus),
      .DSP_reg_access_o(dsp)
    );

    // Model: m_left counts remaining busy cycles (AC+1 for a transfer, 1 otherwise)
    logic [31:0] m_data0;
    int          m_left;
    logic [2:0]  m_err, set_err;
    logic [15:0] m_regno;
    logic        m_write, m_xfer, m_post, m_busy;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_data0 = '0; m_left = 0; m_err = '0; m_regno = '0;
        m_write = 1'b0; m_xfer = 1'b0; m_post = 1'b0;
      end else begin
        m_busy  = (m_left != 0);
        set_err = '0;
        if (m_busy && (cmd_valid || d0_we)) set_err = (m_err == 3'd0) ? 3'd1 : 3'd0;
        else if (!m_busy && cmd_valid && (m_err == 3'd0)) set_err = spec_err(cmd, halted);
        if (!m_busy && d0_we) m_data0 = d0_in;
        if (m_busy) begin
          if (m_xfer && (m_left == 2) && !m_write) m_data0 = gpr[gpr_idx(m_regno)];
          m_left--;
          if ((m_left == 0) && m_post) m_regno++;
        end else if (cmd_valid && (m_err == 3'd0) && (set_err == 3'd0)) begin
          m_write = cmd[16]; m_xfer = cmd[17]; m_post = cmd[19]; m_regno = cmd[15:0];
          m_left  = cmd[17] ? int'(AC) + 1 : 1;
        end
        m_err = (set_err != 3'd0) ? set_err : (clr ? 3'd0 : m_err);
      end
    end

    always @(negedge clk) begin
      logic        ex_en;
      logic [31:0] ex_bus;
      if (rst_n) begin
        ex_en  = m_xfer && (m_left >= 2);
        ex_bus = ex_en ? (m_write ? m_data0 : gpr[gpr_idx(m_regno)]) : IDLE_PAT;
        cmp("busy",   g, 32'(busy),   32'(m_left != 0));
        cmp("cmderr", g, 32'(cmderr), 32'(m_err));
        cmp("data0",  g, data0,       m_data0);
        cmp("regno",  g, 32'(regno),  32'(m_regno));
        cmp("en",     g, 32'(en),     32'(ex_en));
        cmp("dsp",    g, 32'(dsp),    32'(ex_en));
        cmp("rdwr",   g, 32'(rdwr),   32'(ex_en && m_write));
        cmp("addr",   g, 32'(addr),   ex_en ? 32'(16'h1000 | 16'(gpr_idx(m_regno))) : 32'd0);
        cmp("bus",    g, bus,         ex_bus);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wr_data0(input logic [31:0] d);
    d0_in = d;
    d0_we = 1'b1;
    tick;
    d0_we = 1'b0;
  endtask

  task automatic clear_err;
    clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((g_inst[0].busy || g_inst[1].busy) && (n < 50)) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL wait_idle timeout got=busy expected=idle t=%0t", $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = 32'hA500_0000 + 32'(i);
    gpr[4] = 32'h9;

    // Reset values
    tick; tick;
    cmp("rst_busy",   1, 32'(g_inst[1].busy),   32'd0);
    cmp("rst_data0",  1, g_inst[1].data0,       32'd0);
    cmp("rst_cmderr", 1, 32'(g_inst[1].cmderr), 32'd0);
    cmp("rst_regno",  1, 32'(g_inst[1].regno),  32'd0);
    cmp("rst_en",     0, 32'(g_inst[0].en),     32'd0);
    cmp("rst_bus",    0, g_inst[0].bus,         IDLE_PAT);
    rst_n = 1'b1;
    tick;

    // Read x4 = 9
    send_cmd(32'h0022_1004);
    cmp("rd_en",   0, 32'(g_inst[0].en),   32'd1);
    cmp("rd_addr", 0, 32'(g_inst[0].addr), 32'h1004);
    cmp("rd_rdwr", 0, 32'(g_inst[0].rdwr), 32'd0);
    cmp("rd_bus",  0, g_inst[0].bus,       32'h9);
    tick;
    cmp("rd_en_done", 0, 32'(g_inst[0].en),   32'd0);
    cmp("rd_busy2",   0, 32'(g_inst[0].busy), 32'd1);
    cmp("rd_data0",   0, g_inst[0].data0,     32'h9);
    tick;
    cmp("rd_busy_end", 0, 32'(g_inst[0].busy), 32'd0);
    wait_idle;
    cmp("rd_data0", 1, g_inst[1].data0, 32'h9);

    // Write with postincrement
    wr_data0(32'hDEAD_BEEF);
    send_cmd(32'h002B_1005);
    cmp("wr_rdwr", 1, 32'(g_inst[1].rdwr), 32'd1);
    cmp("wr_bus",  1, g_inst[1].bus,       32'hDEAD_BEEF);
    tick;
    cmp("wr_bus_mid", 1, g_inst[1].bus, 32'hDEAD_BEEF);
    wait_idle;
    cmp("wr_regno", 0, 32'(g_inst[0].regno), 32'h1006);
    cmp("wr_regno", 1, 32'(g_inst[1].regno), 32'h1006);
    cmp("wr_bus_after", 1, g_inst[1].bus, IDLE_PAT);

    // Unsupported cmdtype, then halt error, sticky until cleared
    send_cmd(32'h0122_1004);
    cmp("err_type", 1, 32'(g_inst[1].cmderr), 32'd2);
    clear_err;
    cmp("err_clr", 1, 32'(g_inst[1].cmderr), 32'd0);
    halted = 1'b0;
    send_cmd(32'h0022_1004);
    cmp("err_halt", 1, 32'(g_inst[1].cmderr), 32'd4);
    halted = 1'b1;
    send_cmd(32'h0022_1004);
    cmp("ignored_busy",   1, 32'(g_inst[1].busy),   32'd0);
    cmp("ignored_cmderr", 1, 32'(g_inst[1].cmderr), 32'd4);
    clear_err;
    send_cmd(32'h0022_1004);
    cmp("after_clr_busy", 1, 32'(g_inst[1].busy), 32'd1);
    wait_idle;
    cmp("after_clr_data0", 1, g_inst[1].data0, 32'h9);

    // Busy violation during ACCESS
    gpr[7] = 32'h1234_5678;
    send_cmd(32'h0022_1007);
    cmd = 32'h0022_1004; cmd_valid = 1'b1;
    d0_in = 32'hBAD0_BAD0; d0_we = 1'b1;
    tick;
    cmd_valid = 1'b0; d0_we = 1'b0;
    cmp("busy_err", 1, 32'(g_inst[1].cmderr), 32'd1);
    cmp("busy_err", 0, 32'(g_inst[0].cmderr), 32'd1);
    wait_idle;
    cmp("busy_data0", 1, g_inst[1].data0,     32'h1234_5678);
    cmp("busy_data0", 0, g_inst[0].data0,     32'h1234_5678);
    cmp("busy_regno", 1, 32'(g_inst[1].regno), 32'h1007);
    clear_err;

    // Regno just beyond the GPR range, then the last GPR
    send_cmd(32'h0022_1020);
    cmp("range_err",  1, 32'(g_inst[1].cmderr), 32'd3);
    cmp("range_busy", 1, 32'(g_inst[1].busy),   32'd0);
    cmp("range_en",   1, 32'(g_inst[1].en),     32'd0);
    clear_err;
    send_cmd(32'h0022_101F);
    wait_idle;
    cmp("x31_data0", 1, g_inst[1].data0, 32'hA500_001F);

    // No transfer, postincrement wraps regno
    send_cmd(32'h0028_FFFF);
    cmp("nx_busy",  1, 32'(g_inst[1].busy),  32'd1);
    cmp("nx_en",    1, 32'(g_inst[1].en),    32'd0);
    cmp("nx_regno", 1, 32'(g_inst[1].regno), 32'hFFFF);
    tick;
    cmp("nx_busy_end", 1, 32'(g_inst[1].busy),  32'd0);
    cmp("nx_wrap",     1, 32'(g_inst[1].regno), 32'h0);

    // Reset in the middle of a write access
    wr_data0(32'h55AA_55AA);
    send_cmd(32'h0023_1003);
    cmp("mid_bus", 1, g_inst[1].bus, 32'h55AA_55AA);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_en",     1, 32'(g_inst[1].en),     32'd0);
    cmp("mid_rst_bus",    1, g_inst[1].bus,         IDLE_PAT);
    cmp("mid_rst_busy",   1, 32'(g_inst[1].busy),   32'd0);
    cmp("mid_rst_data0",  1, g_inst[1].data0,       32'd0);
    cmp("mid_rst_cmderr", 1, 32'(g_inst[1].cmderr), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
